// File: rtl/peek_fifo_pkg.sv
// Shared constants, count-width helper and status bundle for peek_fifo.
package peek_fifo_pkg;

  localparam int unsigned DefDataW = 8;
  localparam int unsigned DefDepth = 16;

  // Occupancy needs one extra bit so that DEPTH itself is representable.
  function automatic int unsigned count_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  typedef struct packed {
    logic empty_n;
    logic full;
    logic overflow;
    logic underflow;
  } status_t;

endpackage

// File: rtl/peek_fifo_mem.sv
// DEPTH x DATA_W storage: one synchronous write port, one registered read-before-write
// read port; clear port and storage reset exist only when PEEK_FIFO_CLEAR_EN is defined.
module peek_fifo_mem
  import peek_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned DEPTH  = DefDepth,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
`ifdef PEEK_FIFO_CLEAR_EN
  input  logic              clr_i,
  input  logic [ADDR_W-1:0] clr_addr_i,
`endif
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

`ifdef PEEK_FIFO_CLEAR_EN
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (clr_i) begin
        mem_q[clr_addr_i] <= '0;
      end
      // Later assignment wins, so a push to the slot being cleared keeps its data.
      if (we_i) begin
        mem_q[waddr_i] <= wdata_i;
      end
    end
  end
`else
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/peek_fifo.sv
// Synchronous FIFO with random-access peek, full/count and sticky error flags.
// Optional PEEK_FIFO_CLEAR_EN zeroes storage on reset and on every accepted pop.
module peek_fifo
  import peek_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned DEPTH  = DefDepth,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DATA_W-1:0] data_in,
  input  logic              pop,
  input  logic [ADDR_W-1:0] peek,
  output logic [DATA_W-1:0] data_out,
  output logic              empty_n,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int unsigned CntW = count_w(DEPTH);
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              push_ok, pop_ok;
  logic [ADDR_W-1:0] raddr;
  status_t           status;

  assign status = '{
    empty_n:   (count_q != '0),
    full:      (count_q == DepthCnt),
    overflow:  ovf_q,
    underflow: udf_q
  };

  assign pop_ok  = pop && status.empty_n;
  assign push_ok = push && (!status.full || pop_ok);
  assign raddr   = rd_ptr_q + peek;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    if (push && status.full && !pop_ok) ovf_d = 1'b1;
    if (pop && !status.empty_n)         udf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

`ifdef PEEK_FIFO_CLEAR_EN
  logic clr;
  assign clr = pop_ok && reset_n;
`endif

  peek_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk_i      (clk),
    .rst_ni     (reset_n),
    .we_i       (push_ok && reset_n),
    .waddr_i    (wr_ptr_q),
    .wdata_i    (data_in),
`ifdef PEEK_FIFO_CLEAR_EN
    .clr_i      (clr),
    .clr_addr_i (rd_ptr_q),
`endif
    .raddr_i    (raddr),
    .rdata_o    (data_out)
  );

  assign empty_n   = status.empty_n;
  assign full      = status.full;
  assign count     = count_q;
  assign overflow  = status.overflow;
  assign underflow = status.underflow;

endmodule
